fifo_stream_out: RTL and testbench

Downstream read-side bridge for the 8-bit, 16-deep synchronous FIFO. It issues reads on the FIFO read port (`rd_en`/`empty`/`dout`) and captures the returned bytes a fixed latency later. Those bytes go into a small local skid buffer, which presents them on a valid/ready byte stream toward the consumer. An enable/drain state machine lets software stop the stream cleanly, with no bytes lost in flight.

---
 rtl/fifo_stream_out.sv | 181 ++++++++++++++++++
 tb/tb_fifo_stream_out.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_out.sv
// fifo_stream_out: read-side bridge from the 8-bit synchronous FIFO to a
// valid/ready byte stream. Reads are issued against a credit check, their
// data is captured RD_LAT cycles later into a small skid buffer, and the
// buffer head is presented to the consumer. An IDLE/RUN/DRAIN machine lets
// the stream be stopped without losing bytes already requested.
// Optional feature macro: STREAM_PARITY_EN adds the m_par output and
// stores a parity bit alongside each buffered byte.
module fifo_stream_out #(
   parameter int RD_LAT    = 2,
   parameter int BUF_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        fifo_empty,
   input  logic [7:0]  fifo_dout,
   output logic        fifo_rd_en,
   output logic        m_valid,
   output logic [7:0]  m_data,
`ifdef STREAM_PARITY_EN
   output logic        m_par,
`endif
   input  logic        m_ready,
   output logic        idle,
   output logic [15:0] byte_cnt
);

   localparam int DATA_W = 8;
   localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam int SUM_W  = CNT_W + 3;
`ifdef STREAM_PARITY_EN
   localparam int ENT_W  = DATA_W + 1;
`else
   localparam int ENT_W  = DATA_W;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Number of reads currently travelling through the FIFO read latency.
   function automatic logic [2:0] popcnt(input logic [RD_LAT-1:0] v);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         n = n + {2'b00, v[i]};
      end
      return n;
   endfunction

`ifdef STREAM_PARITY_EN
   // Even parity: XOR of all data bits.
   function automatic logic even_par(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction
`endif

   state_t                    state_q;
   logic [RD_LAT-1:0]         rd_vld_p1;
   logic [ENT_W-1:0]          buf_mem [BUF_DEPTH];
   logic [PTR_W-1:0]          wptr_q;
   logic [PTR_W-1:0]          rptr_q;
   logic [CNT_W-1:0]          count_q;
   logic [2:0]                inflight;
   logic [SUM_W-1:0]          credit_used;
   logic                      cap;
   logic                      xfer;
   logic [ENT_W-1:0]          cap_ent;
   logic [ENT_W-1:0]          head_ent;

   assign inflight    = popcnt(rd_vld_p1);
   assign credit_used = SUM_W'(count_q) + SUM_W'(inflight);
   assign cap         = rd_vld_p1[RD_LAT-1];
   assign m_valid     = (count_q != '0);
   assign xfer        = m_valid & m_ready;
   assign head_ent    = buf_mem[rptr_q];
   assign m_data      = head_ent[DATA_W-1:0];

`ifdef STREAM_PARITY_EN
   assign cap_ent = {even_par(fifo_dout), fifo_dout};
   assign m_par   = head_ent[DATA_W];
`else
   assign cap_ent = fifo_dout;
`endif

   // Issue a read only while running, data is available and a buffer slot
   // is reserved for every read that has not yet landed.
   assign fifo_rd_en = (state_q == ST_RUN) & ~fifo_empty &
                       (credit_used < SUM_W'(BUF_DEPTH));

   // Enable/drain state machine; idle is registered alongside the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         idle    <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (en) begin
                  state_q <= ST_RUN;
                  idle    <= 1'b0;
               end
            end
            ST_RUN: begin
               if (!en) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (en) begin
                  state_q <= ST_RUN;
               end else if ((inflight == 3'd0) && (count_q == '0)) begin
                  state_q <= ST_IDLE;
                  idle    <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               idle    <= 1'b1;
            end
         endcase
      end
   end

   // Stage p1: read-return tracking, one bit per cycle of FIFO read latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_vld_p1 <= '0;
      end else begin
         rd_vld_p1 <= (rd_vld_p1 << 1) | RD_LAT'(fifo_rd_en);
      end
   end

   // Capture returning FIFO data into the skid buffer at the write pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_mem[i] <= '0;
         end
         wptr_q <= '0;
      end else if (cap) begin
         buf_mem[wptr_q] <= cap_ent;
         wptr_q          <= wptr_q + PTR_W'(1);
      end
   end

   // Advance the read pointer on every accepted output byte.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rptr_q <= '0;
      end else if (xfer) begin
         rptr_q <= rptr_q + PTR_W'(1);
      end
   end

   // Occupancy: a simultaneous capture and transfer leaves it unchanged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         case ({cap, xfer})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Delivered-byte counter, wrapping modulo 2^16.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_cnt <= '0;
      end else if (xfer) begin
         byte_cnt <= byte_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_fifo_stream_out.sv
// Bench for fifo_stream_out: a behavioural 2-cycle-latency FIFO feeds the
// DUT; a cycle table covers startup, then directed sequences cover
// backpressure, drain, empty toggling, reset and (optionally) parity.
module tb_fifo_stream_out;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        fifo_empty;
   logic [7:0]  fifo_dout;
   logic        fifo_rd_en;
   logic        m_valid;
   logic [7:0]  m_data;
   logic        m_ready;
   logic        idle;
   logic [15:0] byte_cnt;
`ifdef STREAM_PARITY_EN
   logic        m_par;
`endif

   fifo_stream_out #(.RD_LAT(2), .BUF_DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd_en (fifo_rd_en),
      .m_valid    (m_valid),
      .m_data     (m_data),
`ifdef STREAM_PARITY_EN
      .m_par      (m_par),
`endif
      .m_ready    (m_ready),
      .idle       (idle),
      .byte_cnt   (byte_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural FIFO: read data appears two cycles after a sampled rd_en.
   logic [7:0] mem [0:255];
   int         wr_idx = 0;
   int         rd_idx = 0;
   int         rd_cnt = 0;
   logic [7:0] d0 = 8'h00;
   logic [7:0] d1 = 8'h00;
   logic       force_empty = 1'b0;

   assign fifo_empty = (rd_idx == wr_idx) | force_empty;
   assign fifo_dout  = d1;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_idx <= wr_idx;
         d0     <= 8'h00;
         d1     <= 8'h00;
      end else begin
         d1 <= d0;
         if (fifo_rd_en) begin
            d0     <= mem[rd_idx[7:0]];
            rd_idx <= rd_idx + 1;
            rd_cnt <= rd_cnt + 1;
         end else begin
            d0 <= 8'h00;
         end
      end
   end

   int n_tests = 0;
   int n_fail  = 0;
   int exp_idx = 0;
   int n_deliv = 0;
   int base    = 0;
   int k       = 0;

   typedef struct {
      logic        en;
      logic        rdy;
      logic        e_rd;
      logic        e_mv;
      logic [7:0]  e_data;
      logic        e_idle;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_idx[7:0]] = b;
      wr_idx++;
   endtask

   // One cycle: optionally toggle the empty flag, then check ordering rules.
   task automatic step(input bit tog);
      @(negedge clk);
      if (tog) force_empty = ~force_empty;
      #1;
      if (tog) chk("rd_while_empty", {31'd0, fifo_rd_en & fifo_empty}, 0);
      if (m_valid && m_ready) begin
         chk("order", {24'd0, m_data}, {24'd0, mem[exp_idx[7:0]]});
         exp_idx++;
         n_deliv++;
      end
      if (idle) chk("idle_with_valid", {31'd0, m_valid}, 0);
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      while (!idle && c < 20) begin
         step(1'b0);
         c++;
      end
      chk("idle_reached", {31'd0, idle}, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'd0};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
      tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
      tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 16'd0};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 16'd1};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 16'd2};
      tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd3};
      tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd3};
      tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'd3};

      rst = 1'b0;
      en = 1'b0;
      m_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_rd_en", {31'd0, fifo_rd_en}, 0);
      chk("rst_m_valid", {31'd0, m_valid}, 0);
      chk("rst_m_data", {24'd0, m_data}, 0);
      chk("rst_idle", {31'd0, idle}, 1);
      chk("rst_byte_cnt", {16'd0, byte_cnt}, 0);
`ifdef STREAM_PARITY_EN
      chk("rst_m_par", {31'd0, m_par}, 0);
`endif
      @(negedge clk);
      rst = 1'b1;
      exp_idx = wr_idx;
      push(8'h11);
      push(8'h22);
      push(8'h33);

      // Startup and three-byte stream, cycle by cycle.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         en = tbl[i].en;
         m_ready = tbl[i].rdy;
         #1;
         chk($sformatf("t1_rd_en[%0d]", i), {31'd0, fifo_rd_en}, {31'd0, tbl[i].e_rd});
         chk($sformatf("t1_m_valid[%0d]", i), {31'd0, m_valid}, {31'd0, tbl[i].e_mv});
         chk($sformatf("t1_m_data[%0d]", i), {24'd0, m_data}, {24'd0, tbl[i].e_data});
         chk($sformatf("t1_idle[%0d]", i), {31'd0, idle}, {31'd0, tbl[i].e_idle});
         chk($sformatf("t1_byte_cnt[%0d]", i), {16'd0, byte_cnt}, {16'd0, tbl[i].e_cnt});
      end
      exp_idx += 3;

      // Backpressure: ten bytes queued, consumer stalled.
      base = rd_cnt;
      for (int i = 0; i < 10; i++) push(8'hA0 + 8'(i));
      m_ready = 1'b0;
      en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         #1;
         if (m_valid) chk("bp_hold_data", {24'd0, m_data}, 32'hA0);
      end
      chk("bp_reads", rd_cnt - base, 4);
      chk("bp_valid", {31'd0, m_valid}, 1);
      m_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) begin
            @(negedge clk);
            #1;
         end
         chk($sformatf("bp_flow_valid[%0d]", i), {31'd0, m_valid}, 1);
         chk($sformatf("bp_flow_data[%0d]", i), {24'd0, m_data}, {24'd0, mem[exp_idx[7:0]]});
         exp_idx++;
      end
      @(negedge clk);
      #1;
      chk("bp_byte_cnt", {16'd0, byte_cnt}, 13);
      chk("bp_empty_after", {31'd0, m_valid}, 0);
      en = 1'b0;
      wait_idle();

      // Enable dropped while the second of eight reads is being issued.
      base = rd_cnt;
      n_deliv = 0;
      for (int i = 0; i < 8; i++) push(8'hB0 + 8'(i));
      m_ready = 1'b1;
      en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         if ((rd_cnt - base) == 1 && fifo_rd_en) begin
            en = 1'b0;
            break;
         end
      end
      for (int i = 0; i < 12; i++) step(1'b0);
      chk("drain_reads", rd_cnt - base, 2);
      chk("drain_delivered", n_deliv, 2);
      chk("drain_idle", {31'd0, idle}, 1);
      chk("drain_valid", {31'd0, m_valid}, 0);

      // fifo_empty toggling every cycle; remaining B bytes then C bytes.
      n_deliv = 0;
      for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
      en = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 60; i++) step(1'b1);
      chk("toggle_delivered", n_deliv, 10);
      force_empty = 1'b0;
      en = 1'b0;
      wait_idle();

      // Reset asserted while three bytes sit in the buffer.
      for (int i = 0; i < 5; i++) push(8'hD0 + 8'(i));
      m_ready = 1'b0;
      en = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      chk("pre_rst_valid", {31'd0, m_valid}, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_rd_en", {31'd0, fifo_rd_en}, 0);
      chk("mid_rst_m_valid", {31'd0, m_valid}, 0);
      chk("mid_rst_m_data", {24'd0, m_data}, 0);
      chk("mid_rst_idle", {31'd0, idle}, 1);
      chk("mid_rst_byte_cnt", {16'd0, byte_cnt}, 0);
      @(negedge clk);
      rst = 1'b1;
      exp_idx = wr_idx;
      n_deliv = 0;
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(1'b0);
         chk("post_rst_no_stale", {31'd0, m_valid}, 0);
      end
      push(8'hE0);
      push(8'hE1);
      for (int i = 0; i < 10; i++) step(1'b0);
      chk("post_rst_delivered", n_deliv, 2);
      chk("post_rst_byte_cnt", {16'd0, byte_cnt}, 2);

`ifdef STREAM_PARITY_EN
      begin
         logic exp_par [3];
         exp_par[0] = 1'b0;
         exp_par[1] = 1'b1;
         exp_par[2] = 1'b0;
         push(8'h00);
         push(8'h01);
         push(8'hFF);
         k = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (m_valid && m_ready && k < 3) begin
               chk("par_data", {24'd0, m_data}, {24'd0, mem[exp_idx[7:0]]});
               chk($sformatf("par_bit[%0d]", k), {31'd0, m_par}, {31'd0, exp_par[k]});
               exp_idx++;
               k++;
            end
         end
         chk("par_count", k, 3);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
